score_plotter: RTL and testbench

Sequential renderer that takes the 90-bit three-digit score bitmap from the score-to-bitmap decoder and writes it pixel by pixel into the VGA framebuffer adapter. On a `start` pulse it snapshots the bitmap and walks 3 digits × 5 rows × 6 columns. It emits one `plot` strobe per pixel with coordinates and colour. Every pixel is written in either foreground or background colour, so each redraw fully erases the previous score.

---
 rtl/score_plotter.sv | 104 ++++++++++
 tb/tb_score_plotter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/score_plotter.sv
// Renders a captured 3-digit, 5x6-per-digit score bitmap into the framebuffer,
// one pixel per cycle, with every pixel written as foreground or background.
module score_plotter #(
  parameter logic [7:0] X0          = 8'd4,
  parameter logic [6:0] Y0          = 7'd2,
  parameter logic [7:0] DIGIT_PITCH = 8'd7,
  parameter logic [2:0] FG_COLOUR   = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [89:0] score_display,
  output logic [7:0]  x_out,
  output logic [6:0]  y_out,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  state_t      state;
  logic [89:0] snap;
  logic [1:0]  k;
  logic [2:0]  r;
  logic [2:0]  c;
  logic [7:0]  x_nxt;
  logic [6:0]  y_nxt;

  assign x_nxt = X0 + DIGIT_PITCH * {6'd0, k} + {5'd0, c};
  assign y_nxt = Y0 + {4'd0, r};

  // Pixel 0 is emitted on the capture edge straight from score_display; the
  // snapshot is stored pre-shifted so snap[0] is always the next pixel's bit.
  // k reaching 3 (not a wrap) marks that pixel 89 has been issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      snap   <= '0;
      k      <= '0;
      r      <= '0;
      c      <= '0;
      x_out  <= '0;
      y_out  <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          plot <= 1'b0;
          done <= 1'b0;
          if (start) begin
            snap   <= {1'b0, score_display[89:1]};
            x_out  <= X0;
            y_out  <= Y0;
            colour <= score_display[0] ? FG_COLOUR : BG_COLOUR;
            plot   <= 1'b1;
            busy   <= 1'b1;
            k      <= 2'd0;
            r      <= 3'd0;
            c      <= 3'd1;
            state  <= DRAW;
          end
        end
        DRAW: begin
          if (k == 2'd3) begin
            plot  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            plot   <= 1'b1;
            x_out  <= x_nxt;
            y_out  <= y_nxt;
            colour <= snap[0] ? FG_COLOUR : BG_COLOUR;
            snap   <= {1'b0, snap[89:1]};
            if (c == 3'd5) begin
              c <= 3'd0;
              if (r == 3'd4) begin
                r <= 3'd0;
                k <= k + 2'd1;
              end else begin
                r <= r + 3'd1;
              end
            end else begin
              c <= c + 3'd1;
            end
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          k     <= 2'd0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_plotter.sv
// Scoreboard bench for score_plotter: expected pixels are queued when a draw is
// requested and popped as plot strobes appear.
module tb_score_plotter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [89:0] score_display;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  score_plotter dut (
    .clk(clk), .reset(reset), .start(start), .score_display(score_display),
    .x_out(x_out), .y_out(y_out), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0;
  int n_plot, n_done, n_fg, n_busy, n_rise, first_plot, last_plot, done_cyc, rise2;
  logic prev_plot = 1'b0;
  logic [17:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [29:0] glyph(input int d);
    case (d)
      0:       return {6'b001100, 6'b010010, 6'b010010, 6'b010010, 6'b001100};
      1:       return {5{6'b000100}};
      default: return {6'b001100, 6'b010010, 6'b001100, 6'b010010, 6'b001100};
    endcase
  endfunction

  task automatic push_draw(input logic [89:0] bm);
    for (int k = 0; k < 3; k++)
      for (int r = 0; r < 5; r++)
        for (int c = 0; c < 6; c++)
          exp_q.push_back({8'(4 + 7 * k + c), 7'(2 + r),
                           bm[30 * k + 6 * r + c] ? 3'd7 : 3'd0});
  endtask

  task automatic clear_stats();
    n_plot = 0; n_done = 0; n_fg = 0; n_busy = 0; n_rise = 0;
    first_plot = -1000; last_plot = -1000; done_cyc = -1000; rise2 = -1000;
  endtask

  task automatic tick();
    logic [17:0] e;
    @(negedge clk);
    cyc++;
    if (busy) n_busy++;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (plot) begin
      if (!prev_plot) begin
        n_rise++;
        if (n_rise == 2) rise2 = cyc;
      end
      if (first_plot < 0) first_plot = cyc;
      last_plot = cyc;
      n_plot++;
      if (colour == 3'd7) n_fg++;
      if (exp_q.size() == 0) check("plot_unexp", 32'(plot), 32'd0);
      else begin
        e = exp_q.pop_front();
        check("pix", 32'({x_out, y_out, colour}), 32'(e));
      end
    end
    prev_plot = plot;
  endtask

  task automatic draw_and_check(input string tag, input logic [89:0] bm, input int exp_fg);
    clear_stats();
    push_draw(bm);
    score_display = bm;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    repeat (94) tick();
    check({tag, "_first"}, 32'(first_plot - t0), 32'd1);
    check({tag, "_last"}, 32'(last_plot - t0), 32'd90);
    check({tag, "_nplot"}, 32'(n_plot), 32'd90);
    check({tag, "_ndone"}, 32'(n_done), 32'd1);
    check({tag, "_done_at"}, 32'(done_cyc - t0), 32'd91);
    check({tag, "_nbusy"}, 32'(n_busy), 32'd91);
    check({tag, "_nfg"}, 32'(n_fg), 32'(exp_fg));
    check({tag, "_q_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  logic [89:0] bm100, bm888;

  initial begin
    bm100 = {glyph(0), glyph(0), glyph(1)};
    bm888 = {glyph(8), glyph(8), glyph(8)};
    reset = 1'b1;
    start = 1'b0;
    score_display = '0;
    clear_stats();
    repeat (3) tick();
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_y", 32'(y_out), 32'd0);
    check("rst_colour", 32'(colour), 32'd0);
    check("rst_plot", 32'(plot), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    repeat (20) tick();
    check("idle_nplot", 32'(n_plot), 32'd0);

    // reset and start together: reset wins
    reset = 1'b1;
    start = 1'b1;
    score_display = bm888;
    tick();
    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();
    check("rst_start_busy", 32'(n_busy), 32'd0);
    check("rst_start_nplot", 32'(n_plot), 32'd0);

    draw_and_check("s100", bm100, 25);
    draw_and_check("s888", bm888, 30);

    // start pulse mid-draw ignored, input change after capture ignored
    clear_stats();
    push_draw(bm100);
    score_display = bm100;
    start = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel <= 95; rel++) begin
      tick();
      if (rel == 1) start = 1'b0;
      if (rel == 40) start = 1'b1;
      if (rel == 41) begin
        start = 1'b0;
        score_display = '1;
      end
    end
    check("snap_nplot", 32'(n_plot), 32'd90);
    check("snap_ndone", 32'(n_done), 32'd1);
    check("snap_done_at", 32'(done_cyc - t0), 32'd91);
    check("snap_nrise", 32'(n_rise), 32'd1);
    check("snap_nfg", 32'(n_fg), 32'd25);

    // reset mid-draw aborts without done
    clear_stats();
    push_draw(bm888);
    score_display = bm888;
    start = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel <= 100; rel++) begin
      tick();
      if (rel == 1) start = 1'b0;
      if (rel == 50) reset = 1'b1;
      if (rel == 51) reset = 1'b0;
    end
    check("abort_nplot", 32'(n_plot), 32'd50);
    check("abort_last", 32'(last_plot - t0), 32'd50);
    check("abort_ndone", 32'(n_done), 32'd0);
    check("abort_nbusy", 32'(n_busy), 32'd50);
    exp_q.delete();
    draw_and_check("redraw", bm888, 30);

    // held start gives back-to-back draws
    clear_stats();
    push_draw(bm100);
    push_draw(bm100);
    score_display = bm100;
    start = 1'b1;
    t0 = cyc;
    for (int rel = 1; rel <= 200; rel++) begin
      tick();
      if (n_done == 2) start = 1'b0;
    end
    check("held_first", 32'(first_plot - t0), 32'd1);
    check("held_second", 32'(rise2 - t0), 32'd93);
    check("held_nplot", 32'(n_plot), 32'd180);
    check("held_ndone", 32'(n_done), 32'd2);
    check("held_q_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
